// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_DEC = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_NOT = 4'hA;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one iteration per cycle.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              is_div,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic              busy,
  output logic              finish,
  output logic [DWIDTH-1:0] lo_nxt,
  output logic [DWIDTH-1:0] hi_nxt
);

  localparam int CW = $clog2(DWIDTH + 1);

  logic [CW-1:0]     cnt;
  logic              mode;
  logic [DWIDTH-1:0] lo;
  logic [DWIDTH-1:0] hi;
  logic [DWIDTH-1:0] opnd;
  logic [DWIDTH:0]   sum;
  logic [DWIDTH:0]   shifted;
  logic [DWIDTH:0]   diff;

  // finish flags the last iteration; its result is taken from lo_nxt/hi_nxt
  assign finish = busy && (cnt == CW'(DWIDTH - 1));

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[DWIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (mode) begin
      if (shifted >= {1'b0, opnd}) begin
        hi_nxt = diff[DWIDTH-1:0];
        lo_nxt = {lo[DWIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[DWIDTH-1:0];
        lo_nxt = {lo[DWIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[DWIDTH:1];
      lo_nxt = {sum[0], lo[DWIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (finish) busy <= 1'b0;
    end
  end

  // MUL: lo holds the multiplier, opnd the multiplicand; DIV: lo holds the dividend, opnd the divisor
  always_ff @(posedge clk) begin
    if (load) begin
      mode <= is_div;
      lo   <= is_div ? a : b;
      opnd <= is_div ? b : a;
      hi   <= '0;
    end else if (busy) begin
      lo <= lo_nxt;
      hi <= hi_nxt;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MUL/DIV behind a START/BUSY/DONE handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [3:0]        IN_INSTR,
  input  logic [DWIDTH-1:0] IN_A,
  input  logic [DWIDTH-1:0] IN_B,
  input  logic              Cin,
  input  logic              Bin,
  output logic              BUSY,
  output logic              DONE,
  output logic [DWIDTH-1:0] OUT,
  output logic [DWIDTH-1:0] OUT_HI,
  output logic              Cout,
  output logic              Bout,
  output logic              EN_C,
  output logic              EN_B,
  output logic              ZERO,
  output logic              DIV0
);

  localparam int W1 = DWIDTH + 1;

  state_t            state;
  logic              div0_pend;
  logic              load;
  logic              it_finish;
  logic [DWIDTH-1:0] it_lo;
  logic [DWIDTH-1:0] it_hi;
  logic [DWIDTH:0]   add_s;
  logic [DWIDTH:0]   sub_s;
  logic [DWIDTH-1:0] res;
  logic              cfl;
  logic              bfl;
  logic              wr_c;
  logic              wr_b;
  logic              nop;

  assign load = (state == ST_IDLE) && START && is_iter(IN_INSTR);

  alu_iter_muldiv #(.DWIDTH(DWIDTH)) u_iter (
    .clk    (CLK),
    .rst    (RST),
    .load   (load),
    .is_div (IN_INSTR == OP_DIV),
    .a      (IN_A),
    .b      (IN_B),
    .busy   (BUSY),
    .finish (it_finish),
    .lo_nxt (it_lo),
    .hi_nxt (it_hi)
  );

  always_comb begin
    add_s = {1'b0, IN_A} + {1'b0, IN_B} + W1'(Cin);
    sub_s = {1'b0, IN_A} - {1'b0, IN_B} - W1'(Bin);
    res   = '0;
    cfl   = 1'b0;
    bfl   = 1'b0;
    wr_c  = 1'b0;
    wr_b  = 1'b0;
    nop   = 1'b0;
    case (IN_INSTR)
      OP_AND: res = IN_A & IN_B;
      OP_OR:  res = IN_A | IN_B;
      OP_XOR: res = IN_A ^ IN_B;
      OP_NOT: res = ~IN_A;
      OP_SUB: begin res = sub_s[DWIDTH-1:0]; bfl = sub_s[DWIDTH]; wr_b = 1'b1; end
      OP_ADD: begin res = add_s[DWIDTH-1:0]; cfl = add_s[DWIDTH]; wr_c = 1'b1; end
      OP_SHL: begin res = {IN_A[DWIDTH-2:0], 1'b0}; cfl = IN_A[DWIDTH-1]; wr_c = 1'b1; end
      OP_SHR: begin res = {1'b0, IN_A[DWIDTH-1:1]}; cfl = IN_A[0]; wr_c = 1'b1; end
      OP_DEC: begin res = IN_A - DWIDTH'(1); bfl = (IN_A == '0); wr_b = 1'b1; end
      OP_INC: begin res = IN_A + DWIDTH'(1); cfl = (IN_A == '1); wr_c = 1'b1; end
      OP_MUL, OP_DIV: nop = 1'b0;
      default: nop = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      DONE   <= 1'b0;
      OUT    <= '0;
      OUT_HI <= '0;
      Cout   <= 1'b0;
      Bout   <= 1'b0;
      EN_C   <= 1'b0;
      EN_B   <= 1'b0;
      ZERO   <= 1'b0;
      DIV0   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            div0_pend <= (IN_INSTR == OP_DIV) && (IN_B == '0);
            if (is_iter(IN_INSTR)) begin
              state <= ST_EXEC;
            end else begin
              DONE <= 1'b1;
              if (!nop) begin
                OUT    <= res;
                OUT_HI <= '0;
                ZERO   <= (res == '0);
                EN_C   <= wr_c;
                EN_B   <= wr_b;
                DIV0   <= 1'b0;
                if (wr_c) Cout <= cfl;
                if (wr_b) Bout <= bfl;
              end
            end
          end
        end
        ST_EXEC: begin
          if (it_finish) begin
            state  <= ST_IDLE;
            DONE   <= 1'b1;
            OUT    <= it_lo;
            OUT_HI <= it_hi;
            ZERO   <= ({it_hi, it_lo} == '0);
            EN_C   <= 1'b0;
            EN_B   <= 1'b0;
            DIV0   <= div0_pend;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (DWIDTH=8) with hand-computed results, flags and latencies.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [3:0]    IN_INSTR;
  logic [DW-1:0] IN_A;
  logic [DW-1:0] IN_B;
  logic          Cin;
  logic          Bin;
  logic          BUSY;
  logic          DONE;
  logic [DW-1:0] OUT;
  logic [DW-1:0] OUT_HI;
  logic          Cout;
  logic          Bout;
  logic          EN_C;
  logic          EN_B;
  logic          ZERO;
  logic          DIV0;

  // flag byte order: BUSY DONE Cout Bout | EN_C EN_B ZERO DIV0
  logic [7:0] flags;
  assign flags = {BUSY, DONE, Cout, Bout, EN_C, EN_B, ZERO, DIV0};

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_seq #(.DWIDTH(DW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .IN_INSTR (IN_INSTR),
    .IN_A     (IN_A),
    .IN_B     (IN_B),
    .Cin      (Cin),
    .Bin      (Bin),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .OUT      (OUT),
    .OUT_HI   (OUT_HI),
    .Cout     (Cout),
    .Bout     (Bout),
    .EN_C     (EN_C),
    .EN_B     (EN_B),
    .ZERO     (ZERO),
    .DIV0     (DIV0)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b (%h) expected %b (%h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic bi);
    IN_INSTR = op;
    IN_A     = a;
    IN_B     = b;
    Cin      = ci;
    Bin      = bi;
    START    = 1'b1;
    step();
    START    = 1'b0;
  endtask

  task automatic run_iter(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input bit poke, output int lat, output int bc);
    issue(op, a, b, 1'b0, 1'b0);
    lat = 1;
    bc  = 0;
    while (DONE !== 1'b1 && lat < 20) begin
      if (BUSY === 1'b1) bc++;
      if (poke && lat == 3) begin
        START    = 1'b1;
        IN_INSTR = OP_ADD;
        IN_A     = 8'h01;
        IN_B     = 8'h01;
      end
      step();
      START = 1'b0;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bc;
    int dcnt;
    RST = 1'b1; START = 1'b0; IN_INSTR = OP_NOP; IN_A = '0; IN_B = '0; Cin = 1'b0; Bin = 1'b0;
    step();
    step();
    RST = 1'b0;
    check("reset out", OUT, 8'h00);
    check("reset out_hi", OUT_HI, 8'h00);
    check("reset flags", flags, 8'b0000_0000);

    issue(OP_ADD, 8'h0A, 8'h0B, 1'b1, 1'b0);
    check("add1 out", OUT, 8'h16);
    check("add1 flags", flags, 8'b0100_1000);
    step();
    check("add1 done pulse", flags, 8'b0000_1000);

    issue(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
    check("add2 out", OUT, 8'h00);
    check("add2 flags", flags, 8'b0110_1010);

    issue(OP_INC, 8'h20, 8'h00, 1'b0, 1'b0);
    check("inc out", OUT, 8'h21);
    check("inc flags", flags, 8'b0100_1000);

    issue(OP_SUB, 8'h03, 8'h1F, 1'b0, 1'b1);
    check("sub out", OUT, 8'hE3);
    check("sub flags", flags, 8'b0101_0100);

    issue(OP_DEC, 8'h00, 8'h00, 1'b0, 1'b0);
    check("dec out", OUT, 8'hFF);
    check("dec flags", flags, 8'b0101_0100);

    issue(OP_SHL, 8'h81, 8'h00, 1'b0, 1'b0);
    check("shl out", OUT, 8'h02);
    check("shl flags", flags, 8'b0111_1000);

    issue(OP_SHR, 8'h03, 8'h00, 1'b0, 1'b0);
    check("shr out", OUT, 8'h01);
    check("shr flags", flags, 8'b0111_1000);

    issue(4'hE, 8'h00, 8'h00, 1'b0, 1'b0);
    check("nop out hold", OUT, 8'h01);
    check("nop flags hold", flags, 8'b0111_1000);

    issue(OP_AND, 8'hF0, 8'h3C, 1'b0, 1'b0);
    check("and out", OUT, 8'h30);
    check("and flags", flags, 8'b0111_0000);

    issue(OP_XOR, 8'hAA, 8'hFF, 1'b0, 1'b0);
    check("xor out", OUT, 8'h55);
    issue(OP_OR, 8'h0F, 8'h30, 1'b0, 1'b0);
    check("or b2b out", OUT, 8'h3F);
    check("or b2b flags", flags, 8'b0111_0000);
    issue(OP_NOT, 8'h5A, 8'h00, 1'b0, 1'b0);
    check("not out", OUT, 8'hA5);

    run_iter(OP_MUL, 8'h70, 8'h20, 1'b1, lat, bc);
    check("mul latency", 8'(lat), 8'd9);
    check("mul busy cycles", 8'(bc), 8'd8);
    check("mul out", OUT, 8'h00);
    check("mul out_hi", OUT_HI, 8'h0E);
    check("mul flags", flags, 8'b0111_0000);

    run_iter(OP_DIV, 8'h70, 8'h09, 1'b0, lat, bc);
    check("div latency", 8'(lat), 8'd9);
    check("div out", OUT, 8'h0C);
    check("div out_hi", OUT_HI, 8'h04);
    check("div flags", flags, 8'b0111_0000);

    run_iter(OP_DIV, 8'h70, 8'h00, 1'b0, lat, bc);
    check("div0 latency", 8'(lat), 8'd9);
    check("div0 out", OUT, 8'hFF);
    check("div0 out_hi", OUT_HI, 8'h70);
    check("div0 flags", flags, 8'b0111_0001);

    issue(OP_INC, 8'hFF, 8'h00, 1'b0, 1'b0);
    check("inc wrap out", OUT, 8'h00);
    check("inc wrap out_hi", OUT_HI, 8'h00);
    check("inc wrap flags", flags, 8'b0111_1010);

    issue(OP_MUL, 8'h70, 8'h20, 1'b0, 1'b0);
    step();
    step();
    step();
    check("abort busy before rst", {7'b0, BUSY}, 8'h01);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("abort out", OUT, 8'h00);
    check("abort out_hi", OUT_HI, 8'h00);
    check("abort flags", flags, 8'b0000_0000);
    dcnt = 0;
    repeat (12) begin
      step();
      if (DONE === 1'b1) dcnt++;
    end
    check("abort no done", 8'(dcnt), 8'd0);

    issue(OP_ADD, 8'h04, 8'h02, 1'b0, 1'b0);
    check("post-rst add out", OUT, 8'h06);
    check("post-rst add flags", flags, 8'b0100_1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
